// File: rtl/cpu_branch_core.sv
// cpu_branch_core: multicycle 16-bit CPU core with conditional/unconditional
// branches, BL/BX, a parametrised PC width and a req/ready memory handshake.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start_pc    PC value loaded while rst_n is low
//   ram_r_data  RAM read data, valid in the cycle ram_ready is high
//   ram_ready   completes the pending RAM request this cycle
//   ram_req     request pending; addr/w_en/w_data stable while high
//   ram_w_en    1 = write request, 0 = read request (qualified by ram_req)
//   ram_addr    request address (PC during fetch, data address during MEM)
//   ram_w_data  store data (register C)
//   out         register C
//   halted      high once a HALT has executed
module cpu_branch_core #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int NREGS  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic [DATA_W-1:0] ram_r_data,
    input  logic              ram_ready,
    output logic              ram_req,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_w_data,
    output logic [DATA_W-1:0] out,
    output logic              halted
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_ALU,
        S_EXEC_ADDR,
        S_EXEC_MEMSET,
        S_EXEC_BR,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_BR    = 3'b001;
    localparam logic [2:0] OP_BL_BX = 3'b010;
    localparam logic [2:0] OP_LDR   = 3'b011;
    localparam logic [2:0] OP_STR   = 3'b100;
    localparam logic [2:0] OP_ALU   = 3'b101;
    localparam logic [2:0] OP_MOV   = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    state_t            state;
    state_t            next_state;
    logic              started;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] c_reg;
    logic              flag_z;
    logic              flag_n;
    logic              flag_v;
    logic [DATA_W-1:0] rf [NREGS];

    logic [2:0]        op;
    logic [1:0]        alu_op;
    logic [2:0]        rn;
    logic [2:0]        rd;
    logic [1:0]        sh;
    logic [2:0]        rm;
    logic signed [DATA_W-1:0] sximm8;
    logic signed [DATA_W-1:0] sximm5;
    logic [ADDR_W-1:0] branch_target;
    logic [ADDR_W-1:0] bx_target;
    logic [DATA_W-1:0] cmp_diff;
    logic              access_done;
    logic              is_store;
    logic              is_mov_imm;
    logic              is_bl;

    logic              rf_we;
    logic [2:0]        rf_wsel;
    logic [DATA_W-1:0] rf_wdata;

    function automatic logic [DATA_W-1:0] shift_f(input logic [DATA_W-1:0] x,
                                                  input logic [1:0]        s);
        case (s)
            2'b01:   return {x[DATA_W-2:0], 1'b0};
            2'b10:   return {1'b0, x[DATA_W-1:1]};
            2'b11:   return {x[DATA_W-1], x[DATA_W-1:1]};
            default: return x;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] alu_f(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [1:0]        f);
        case (f)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return ~b;
        endcase
    endfunction

    function automatic logic cond_f(input logic [2:0] cond, input logic z,
                                    input logic n, input logic v);
        case (cond)
            3'b000:  return 1'b1;
            3'b001:  return z;
            3'b010:  return !z;
            3'b011:  return n != v;
            3'b100:  return (n != v) || z;
            default: return 1'b0;
        endcase
    endfunction

    assign op     = ir[15:13];
    assign alu_op = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sximm8 = signed'({{(DATA_W-8){ir[7]}}, ir[7:0]});
    assign sximm5 = signed'({{(DATA_W-5){ir[4]}}, ir[4:0]});

    // pc is already incremented by the time a branch executes
    assign branch_target = pc + sximm8[ADDR_W-1:0];
    assign bx_target     = rf[rd][ADDR_W-1:0];
    assign cmp_diff      = alu_f(a_reg, b_reg, 2'b01);

    assign is_store   = (op == OP_STR);
    assign is_mov_imm = (op == OP_MOV) && (alu_op == 2'b10);
    assign is_bl      = (op == OP_BL_BX) && (alu_op == 2'b11);

    // started keeps ram_req low until the first edge after reset release
    assign ram_req     = started && ((state == S_FETCH) || (state == S_MEM));
    assign access_done = ram_req && ram_ready;
    assign ram_w_en    = ram_req && (state == S_MEM) && is_store;
    assign ram_addr    = (state == S_MEM) ? data_addr : pc;
    assign ram_w_data  = c_reg;
    assign out         = c_reg;
    assign halted      = (state == S_HALT);

    always_comb begin
        next_state = state;
        unique case (state)
            S_FETCH: if (access_done) next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_ALU:           next_state = S_EXEC_ALU;
                    OP_MOV:           next_state = (alu_op == 2'b10 || alu_op == 2'b00)
                                                   ? S_EXEC_ALU : S_FETCH;
                    OP_LDR, OP_STR:   next_state = S_EXEC_ADDR;
                    OP_BR:            next_state = S_EXEC_BR;
                    OP_BL_BX:         next_state = (alu_op == 2'b11 || alu_op == 2'b00)
                                                   ? S_EXEC_BR : S_FETCH;
                    OP_HALT:          next_state = S_HALT;
                    default:          next_state = S_FETCH;
                endcase
            end
            S_EXEC_ALU:    next_state = (op == OP_ALU && alu_op == 2'b01) ? S_FETCH : S_WB;
            S_EXEC_ADDR:   next_state = S_EXEC_MEMSET;
            S_EXEC_MEMSET: next_state = S_MEM;
            S_MEM:         if (access_done) next_state = is_store ? S_FETCH : S_WB;
            S_WB:          next_state = S_FETCH;
            S_EXEC_BR:     next_state = S_FETCH;
            S_HALT:        next_state = S_HALT;
            default:       next_state = S_FETCH;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_wsel  = rd;
        rf_wdata = c_reg;
        if (state == S_WB) begin
            rf_we   = 1'b1;
            rf_wsel = is_mov_imm ? rn : rd;
        end else if (state == S_EXEC_BR && is_bl) begin
            rf_we    = 1'b1;
            rf_wsel  = 3'd7;
            rf_wdata = DATA_W'(pc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            started <= 1'b0;
            pc      <= start_pc;
            c_reg   <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_v  <= 1'b0;
        end else begin
            state   <= next_state;
            started <= 1'b1;
            case (state)
                S_FETCH: if (access_done) pc <= pc + ADDR_W'(1);
                S_EXEC_ALU: begin
                    if (is_mov_imm) begin
                        c_reg <= sximm8;
                    end else if (op == OP_MOV) begin
                        c_reg <= b_reg;
                    end else if (alu_op == 2'b01) begin
                        flag_z <= (cmp_diff == '0);
                        flag_n <= cmp_diff[DATA_W-1];
                        flag_v <= (a_reg[DATA_W-1] != b_reg[DATA_W-1]) &&
                                  (cmp_diff[DATA_W-1] != a_reg[DATA_W-1]);
                    end else begin
                        c_reg <= alu_f(a_reg, b_reg, alu_op);
                    end
                end
                S_EXEC_ADDR:   c_reg <= a_reg + sximm5;
                S_EXEC_MEMSET: if (is_store) c_reg <= rf[rd];
                S_MEM:         if (access_done && !is_store) c_reg <= ram_r_data;
                S_EXEC_BR: begin
                    if (op == OP_BR) begin
                        if (cond_f(rn, flag_z, flag_n, flag_v)) pc <= branch_target;
                    end else if (is_bl) begin
                        pc <= branch_target;
                    end else begin
                        pc <= bx_target;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_FETCH && access_done) ir <= ram_r_data;
        if (state == S_DECODE) begin
            a_reg <= rf[rn];
            b_reg <= shift_f(rf[rm], sh);
        end
        if (state == S_EXEC_MEMSET) data_addr <= c_reg[ADDR_W-1:0];
        if (rf_we) rf[rf_wsel] <= rf_wdata;
    end

endmodule

// File: tb/tb_cpu_branch_core.sv
module tb_cpu_branch_core;

    logic        clk;
    logic        rst_n;
    logic [7:0]  start_pc;
    logic [15:0] ram_r_data;
    logic        ram_ready;
    logic        ram_req;
    logic        ram_w_en;
    logic [7:0]  ram_addr;
    logic [15:0] ram_w_data;
    logic [15:0] out;
    logic        halted;

    logic        rst4_n;
    logic [3:0]  start_pc4;
    logic [15:0] r_data4;
    logic        ready4;
    logic        req4;
    logic        w_en4;
    logic [3:0]  addr4;
    logic [15:0] w_data4;
    logic [15:0] out4;
    logic        halted4;

    logic [15:0] mem  [256];
    logic [15:0] mem4 [16];

    int n_cmp;
    int n_bad;

    // RAM model state
    int          wait_n;
    int          seen;
    logic        done_flag;
    logic [7:0]  log8 [1024];
    int          ln;
    int          wr_n;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    int          st_cyc;
    int          st_good;
    logic [3:0]  log4 [64];
    int          ln4;

    cpu_branch_core #(.ADDR_W(8), .DATA_W(16), .NREGS(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start_pc(start_pc), .ram_r_data(ram_r_data),
        .ram_ready(ram_ready), .ram_req(ram_req), .ram_w_en(ram_w_en),
        .ram_addr(ram_addr), .ram_w_data(ram_w_data), .out(out), .halted(halted)
    );

    cpu_branch_core #(.ADDR_W(4), .DATA_W(16), .NREGS(8)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .start_pc(start_pc4), .ram_r_data(r_data4),
        .ram_ready(ready4), .ram_req(req4), .ram_w_en(w_en4),
        .ram_addr(addr4), .ram_w_data(w_data4), .out(out4), .halted(halted4)
    );

    assign ram_r_data = mem[ram_addr];
    assign r_data4    = mem4[addr4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with wait_n stalled cycles per request; ready is idle-high.
    initial begin
        ram_ready = 1'b1;
        seen = 0; done_flag = 1'b0; ln = 0; wr_n = 0; st_cyc = 0; st_good = 0;
        wr_addr = '0; wr_data = '0; ln4 = 0; ready4 = 1'b1;
    end

    always @(negedge clk) begin
        if (ram_req) begin
            if (done_flag) seen = 0;
            seen = seen + 1;
            ram_ready = (seen > wait_n);
            done_flag = ram_ready;
            if (ram_w_en) begin
                st_cyc = st_cyc + 1;
                if (ram_addr == 8'd20 && ram_w_data == 16'd5) st_good = st_good + 1;
            end
            if (ram_ready) begin
                if (ram_w_en) begin
                    wr_n = wr_n + 1; wr_addr = ram_addr; wr_data = ram_w_data;
                end else if (ln < 1024) begin
                    log8[ln] = ram_addr; ln = ln + 1;
                end
            end
        end else begin
            seen = 0; done_flag = 1'b0; ram_ready = 1'b1;
        end
        if (req4 && ln4 < 64) begin
            log4[ln4] = addr4; ln4 = ln4 + 1;
        end
    end

    // instruction encoders
    function automatic logic [15:0] f_movi(input logic [2:0] rn, input logic [7:0] imm);
        return {3'b110, 2'b10, rn, imm};
    endfunction
    function automatic logic [15:0] f_alu(input logic [1:0] f, input logic [1:0] s);
        return {3'b101, f, 3'd0, 3'd2, s, 3'd1};
    endfunction
    function automatic logic [15:0] f_movr(input logic [2:0] rd, input logic [1:0] s,
                                           input logic [2:0] rm);
        return {3'b110, 2'b00, 3'd0, rd, s, rm};
    endfunction
    function automatic logic [15:0] f_br(input logic [2:0] cond, input logic [7:0] imm);
        return {3'b001, 2'b00, cond, imm};
    endfunction
    function automatic logic [15:0] f_mem(input logic [2:0] opc, input logic [2:0] rd,
                                          input logic [2:0] rn, input logic [4:0] im5);
        return {opc, 2'b00, rn, rd, im5};
    endfunction

    localparam logic [15:0] I_HALT = 16'hE000;
    localparam logic [15:0] I_CMP  = {3'b101, 2'b01, 3'd0, 3'd0, 2'b00, 3'd1};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic hold_reset(input logic [7:0] spc);
        @(negedge clk);
        rst_n = 1'b0;
        start_pc = spc;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        check(nm, halted, 1);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] instr;
        logic [15:0] exp;
    } alu_vec_t;

    typedef struct {
        logic [2:0] cond;
        logic [7:0] a;
        logic [7:0] b;
        logic       taken;
    } br_vec_t;

    alu_vec_t avec [9];
    br_vec_t  bvec [11];

    initial begin
        int base;
        int req_seen;
        int wr_base;
        int st_base;
        int sg_base;

        avec[0] = '{8'd5,   8'd3,   f_alu(2'b00, 2'b00),        16'h0008};
        avec[1] = '{8'd5,   8'd3,   f_alu(2'b00, 2'b01),        16'h000B};
        avec[2] = '{8'h0C,  8'h0A,  f_alu(2'b10, 2'b00),        16'h0008};
        avec[3] = '{8'h00,  8'h00,  f_alu(2'b11, 2'b00),        16'hFFFF};
        avec[4] = '{8'h00,  8'h01,  f_alu(2'b11, 2'b01),        16'hFFFD};
        avec[5] = '{8'h00,  8'hFE,  f_movr(3'd2, 2'b10, 3'd1),  16'h7FFF};
        avec[6] = '{8'h00,  8'hFE,  f_movr(3'd2, 2'b11, 3'd1),  16'hFFFF};
        avec[7] = '{8'hFF,  8'h01,  f_alu(2'b00, 2'b00),        16'h0000};
        avec[8] = '{8'h7F,  8'h7F,  f_alu(2'b00, 2'b00),        16'h00FE};

        bvec[0]  = '{3'b000, 8'd1, 8'd2, 1'b1};
        bvec[1]  = '{3'b001, 8'd3, 8'd3, 1'b1};
        bvec[2]  = '{3'b001, 8'd1, 8'd2, 1'b0};
        bvec[3]  = '{3'b010, 8'd1, 8'd2, 1'b1};
        bvec[4]  = '{3'b010, 8'd3, 8'd3, 1'b0};
        bvec[5]  = '{3'b011, 8'd1, 8'd2, 1'b1};
        bvec[6]  = '{3'b011, 8'd2, 8'd1, 1'b0};
        bvec[7]  = '{3'b100, 8'd2, 8'd2, 1'b1};
        bvec[8]  = '{3'b100, 8'd2, 8'd1, 1'b0};
        bvec[9]  = '{3'b100, 8'd1, 8'd2, 1'b1};
        bvec[10] = '{3'b101, 8'd3, 8'd3, 1'b0};

        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; rst4_n = 1'b0;
        start_pc = 8'h10; start_pc4 = 4'hF;
        wait_n = 5;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) mem4[i] = 16'h0000;
        mem[8'h10] = I_HALT;
        mem4[0] = f_br(3'b000, 8'hFF);

        // reset values, release timing, async abort of a stalled fetch
        repeat (2) @(negedge clk);
        check("reset_req", ram_req, 0);
        check("reset_wen", ram_w_en, 0);
        check("reset_halted", halted, 0);
        check("reset_out", out, 16'h0000);
        check("reset_addr", ram_addr, 8'h10);
        rst_n = 1'b1;
        #1 check("req_before_edge", ram_req, 0);
        @(negedge clk);
        check("first_req", ram_req, 1);
        check("first_addr", ram_addr, 8'h10);
        repeat (2) @(negedge clk);
        check("stalled_req", ram_req, 1);
        #2 rst_n = 1'b0;
        #1 check("abort_req", ram_req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("refetch_req", ram_req, 1);
        check("refetch_addr", ram_addr, 8'h10);
        wait_n = 0;
        run_until_halt("halt_at_10", 50);

        // datapath vectors: MOV R0,#a; MOV R1,#b; op R2; HALT
        foreach (avec[k]) begin
            hold_reset(8'h00);
            mem[0] = f_movi(3'd0, avec[k].a);
            mem[1] = f_movi(3'd1, avec[k].b);
            mem[2] = avec[k].instr;
            mem[3] = I_HALT;
            release_reset();
            run_until_halt($sformatf("alu%0d_halt", k), 100);
            check($sformatf("alu%0d_out", k), out, avec[k].exp);
        end

        // branch vectors: CMP R0,R1 then Bcond +2 at addr 3
        foreach (bvec[k]) begin
            hold_reset(8'h00);
            mem[0] = f_movi(3'd0, bvec[k].a);
            mem[1] = f_movi(3'd1, bvec[k].b);
            mem[2] = I_CMP;
            mem[3] = f_br(bvec[k].cond, 8'd2);
            mem[4] = f_movi(3'd2, 8'd1);
            mem[5] = f_movi(3'd2, 8'd2);
            mem[6] = I_HALT;
            release_reset();
            base = ln;
            run_until_halt($sformatf("br%0d_halt", k), 100);
            check($sformatf("br%0d_next_fetch", k), log8[base+4], bvec[k].taken ? 8'd6 : 8'd4);
        end

        // store with 3 wait cycles per access, then load back
        hold_reset(8'h00);
        wait_n = 3;
        mem[0] = f_movi(3'd1, 8'd20);
        mem[1] = f_movi(3'd0, 8'd5);
        mem[2] = f_mem(3'b100, 3'd0, 3'd1, 5'd0);
        mem[3] = f_mem(3'b011, 3'd3, 3'd1, 5'd1);
        mem[4] = I_HALT;
        mem[21] = 16'h1234;
        release_reset();
        wr_base = wr_n; st_base = st_cyc; sg_base = st_good;
        run_until_halt("wait_halt", 200);
        check("wait_single_write", wr_n - wr_base, 1);
        check("wait_write_addr", wr_addr, 8'd20);
        check("wait_write_data", wr_data, 16'd5);
        check("wait_store_cycles", st_cyc - st_base, 4);
        check("wait_store_stable", st_good - sg_base, 4);
        check("wait_load_out", out, 16'h1234);
        wait_n = 0;

        // BL / BX call and return; undefined op 000 at 0..3 runs as no-op
        hold_reset(8'h00);
        mem[4]  = {3'b010, 2'b11, 3'b111, 8'd10};
        mem[15] = {3'b010, 2'b00, 3'b000, 3'd7, 5'd0};
        mem[5]  = f_movr(3'd2, 2'b00, 3'd7);
        mem[6]  = I_HALT;
        release_reset();
        base = ln;
        run_until_halt("call_halt", 100);
        check("call_fetch_bl", log8[base+4], 8'd4);
        check("call_target", log8[base+5], 8'd15);
        check("return_fetch", log8[base+6], 8'd5);
        check("r7_link", out, 16'd5);

        // HALT is absorbing; only reset leaves it
        req_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (ram_req) req_seen++;
        end
        check("halt_no_req", req_seen, 0);
        check("halt_sticky", halted, 1);
        rst_n = 1'b0;
        #1 check("halt_cleared", halted, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 4-bit PC: fetch at 15 wraps to 0; B -1 at 0 loops on 0
        @(negedge clk);
        rst4_n = 1'b1;
        repeat (20) @(negedge clk);
        check("wrap_fetch0", log4[0], 4'hF);
        check("wrap_fetch1", log4[1], 4'h0);
        check("loop_fetch2", log4[2], 4'h0);
        check("loop_fetch3", log4[3], 4'h0);
        check("wrap_no_write", w_en4, 0);
        check("wrap_not_halted", halted4, 0);
        check("wrap_out", out4, 16'h0000);
        check("wrap_wdata", w_data4, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
